// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared constants and FSM encoding for the interrupt scheduler
package int_pkg;

    localparam int NUM_SRC = 5;

    localparam logic [2:0] SRC_IE0 = 3'd0;
    localparam logic [2:0] SRC_TF0 = 3'd1;
    localparam logic [2:0] SRC_IE1 = 3'd2;
    localparam logic [2:0] SRC_TF1 = 3'd3;
    localparam logic [2:0] SRC_SER = 3'd4;

    localparam int IE_EX0 = 0;
    localparam int IE_ET0 = 1;
    localparam int IE_EX1 = 2;
    localparam int IE_ET1 = 3;
    localparam int IE_ES  = 4;
    localparam int IE_EA  = 7;

    localparam int IP_PX0 = 0;
    localparam int IP_PT0 = 1;
    localparam int IP_PX1 = 2;
    localparam int IP_PT1 = 3;
    localparam int IP_PS  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/ext_int_detect.sv
// rtl/ext_int_detect.sv - external pin synchroniser with edge/level flag
module ext_int_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_n,
    input  logic edge_mode,
    input  logic ack_clr,
    input  logic sw_clr,
    output logic flag
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   sync_out;
    logic                   fall;

    assign sync_out = sync[SYNC_STAGES-1];
    assign fall     = prev & ~sync_out;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync <= '1;
            prev <= 1'b1;
            flag <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin_n};
            prev <= sync_out;
            if (!edge_mode) begin
                flag <= ~sync_out;
            end else if (fall) begin
                // a new edge outranks a clear landing in the same cycle
                flag <= 1'b1;
            end else if (ack_clr || sw_clr) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/int_sched.sv
// rtl/int_sched.sv - two-level 8051 interrupt priority scheduler with req/ack handshake
module int_sched
    import int_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] VEC_BASE    = 16'h0003
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  ie,
    input  logic [7:0]  ip,
    input  logic        it0,
    input  logic        it1,
    input  logic        int0_n,
    input  logic        int1_n,
    input  logic        tf0,
    input  logic        tf1,
    input  logic        ri_ti,
    input  logic [1:0]  flag_clr,
    input  logic        int_ack,
    input  logic        reti,
    output logic        int_req,
    output logic [15:0] int_vector,
    output logic [2:0]  int_src,
    output logic        ie0_flag,
    output logic        ie1_flag,
    output logic        clr_tf0,
    output logic        clr_tf1,
    output logic [1:0]  in_service
);

    sched_state_t       state, next_state;
    logic               load;
    logic               ack_fire;
    logic [NUM_SRC-1:0] flags;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] elig_high;
    logic [NUM_SRC-1:0] elig_low;
    logic [NUM_SRC-1:0] elig;
    logic [2:0]         pick;
    logic [1:0]         is_next;
    logic               unused_bits;

    assign unused_bits = ^{ie[6:5], ip[7:5]};

    assign ack_fire = (state == REQ) && int_ack;
    assign int_req  = (state == REQ);

    ext_int_detect #(.SYNC_STAGES(SYNC_STAGES)) u_int0 (
        .clk       (clk),
        .reset     (reset),
        .pin_n     (int0_n),
        .edge_mode (it0),
        .ack_clr   (ack_fire && (int_src == SRC_IE0)),
        .sw_clr    (flag_clr[0]),
        .flag      (ie0_flag)
    );

    ext_int_detect #(.SYNC_STAGES(SYNC_STAGES)) u_int1 (
        .clk       (clk),
        .reset     (reset),
        .pin_n     (int1_n),
        .edge_mode (it1),
        .ack_clr   (ack_fire && (int_src == SRC_IE1)),
        .sw_clr    (flag_clr[1]),
        .flag      (ie1_flag)
    );

    assign flags     = {ri_ti, tf1, ie1_flag, tf0, ie0_flag};
    assign pending   = flags & ie[NUM_SRC-1:0] & {NUM_SRC{ie[IE_EA]}};
    assign elig_high = in_service[1] ? '0 : (pending & ip[NUM_SRC-1:0]);
    assign elig_low  = (in_service != 2'b00) ? '0 : (pending & ~ip[NUM_SRC-1:0]);
    assign elig      = (elig_high != '0) ? elig_high : elig_low;

    // lowest index wins within the chosen level
    always_comb begin
        pick = 3'd0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (elig[k]) begin
                pick = 3'(k);
            end
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (elig != '0) begin
                    next_state = REQ;
                    load       = 1'b1;
                end
            end
            REQ: begin
                if (int_ack) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // reti retires the innermost level before a same-cycle ack opens a new one
    always_comb begin
        is_next = in_service;
        if (reti) begin
            if (is_next[1]) begin
                is_next[1] = 1'b0;
            end else begin
                is_next[0] = 1'b0;
            end
        end
        if (ack_fire) begin
            is_next[ip[int_src]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            int_src    <= 3'd0;
            int_vector <= 16'h0000;
            in_service <= 2'b00;
            clr_tf0    <= 1'b0;
            clr_tf1    <= 1'b0;
        end else begin
            if (load) begin
                int_src    <= pick;
                int_vector <= VEC_BASE + {10'd0, pick, 3'b000};
            end
            in_service <= is_next;
            clr_tf0    <= ack_fire && (int_src == SRC_TF0);
            clr_tf1    <= ack_fire && (int_src == SRC_TF1);
        end
    end

endmodule

// File: tb/tb_int_sched.sv
// tb/tb_int_sched.sv - self-checking bench for int_sched against a behavioural model
module tb_int_sched;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  ie = 8'h00;
    logic [7:0]  ip = 8'h00;
    logic        it0 = 1'b0;
    logic        it1 = 1'b0;
    logic        int0_n = 1'b1;
    logic        int1_n = 1'b1;
    logic        tf0 = 1'b0;
    logic        tf1 = 1'b0;
    logic        ri_ti = 1'b0;
    logic [1:0]  flag_clr = 2'b00;
    logic        int_ack = 1'b0;
    logic        reti = 1'b0;
    logic        int_req;
    logic [15:0] int_vector;
    logic [2:0]  int_src;
    logic        ie0_flag;
    logic        ie1_flag;
    logic        clr_tf0;
    logic        clr_tf1;
    logic [1:0]  in_service;

    int vectors = 0;
    int errors = 0;

    bit        m_req, m_f0, m_f1, m_c0, m_c1;
    int        m_src;
    bit [15:0] m_vec;
    bit [1:0]  m_is;
    bit        h0[$];
    bit        h1[$];

    int_sched #(.SYNC_STAGES(SYNC), .VEC_BASE(16'h0003)) dut (
        .clk        (clk),
        .reset      (reset),
        .ie         (ie),
        .ip         (ip),
        .it0        (it0),
        .it1        (it1),
        .int0_n     (int0_n),
        .int1_n     (int1_n),
        .tf0        (tf0),
        .tf1        (tf1),
        .ri_ti      (ri_ti),
        .flag_clr   (flag_clr),
        .int_ack    (int_ack),
        .reti       (reti),
        .int_req    (int_req),
        .int_vector (int_vector),
        .int_src    (int_src),
        .ie0_flag   (ie0_flag),
        .ie1_flag   (ie1_flag),
        .clr_tf0    (clr_tf0),
        .clr_tf1    (clr_tf1),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // highest eligible level first, then lowest source number
    function automatic int pick_src(bit [4:0] fl);
        for (int lvl = 1; lvl >= 0; lvl--) begin
            if (lvl == 1 && m_is[1]) continue;
            if (lvl == 0 && m_is != 2'b00) continue;
            for (int k = 0; k < 5; k++) begin
                if (fl[k] && ie[k] && ie[7] && (int'(ip[k]) == lvl)) return k;
            end
        end
        return -1;
    endfunction

    task automatic model_step();
        bit       s0, p0, s1, p1, ack_fire, n_f0, n_f1;
        bit [4:0] fl;
        bit [1:0] n_is;
        int       w;
        if (!reset) begin
            m_req = 0; m_src = 0; m_vec = 16'h0000; m_f0 = 0; m_f1 = 0;
            m_c0 = 0; m_c1 = 0; m_is = 2'b00;
            h0 = {}; h1 = {};
            repeat (SYNC + 1) begin h0.push_back(1'b1); h1.push_back(1'b1); end
            return;
        end
        s0 = h0[SYNC-1]; p0 = h0[SYNC];
        s1 = h1[SYNC-1]; p1 = h1[SYNC];
        ack_fire = m_req && int_ack;
        fl = {ri_ti, tf1, m_f1, tf0, m_f0};
        if (!it0) n_f0 = !s0;
        else if (p0 && !s0) n_f0 = 1;
        else if ((ack_fire && m_src == 0) || flag_clr[0]) n_f0 = 0;
        else n_f0 = m_f0;
        if (!it1) n_f1 = !s1;
        else if (p1 && !s1) n_f1 = 1;
        else if ((ack_fire && m_src == 2) || flag_clr[1]) n_f1 = 0;
        else n_f1 = m_f1;
        m_c0 = ack_fire && m_src == 1;
        m_c1 = ack_fire && m_src == 3;
        n_is = m_is;
        if (reti) begin
            if (n_is[1]) n_is[1] = 0;
            else n_is[0] = 0;
        end
        if (ack_fire) begin
            n_is[ip[m_src]] = 1;
            m_req = 0;
        end else if (!m_req) begin
            w = pick_src(fl);
            if (w >= 0) begin
                m_req = 1;
                m_src = w;
                m_vec = 16'h0003 + 16'(8 * w);
            end
        end
        m_is = n_is; m_f0 = n_f0; m_f1 = n_f1;
        h0.push_front(int0_n); void'(h0.pop_back());
        h1.push_front(int1_n); void'(h1.pop_back());
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        int_ack = 0; reti = 0; flag_clr = 2'b00;
        chk("m_int_req", int_req, m_req);
        chk("m_int_vector", int_vector, m_vec);
        chk("m_int_src", int_src, m_src[2:0]);
        chk("m_ie0_flag", ie0_flag, m_f0);
        chk("m_ie1_flag", ie1_flag, m_f1);
        chk("m_clr_tf0", clr_tf0, m_c0);
        chk("m_clr_tf1", clr_tf1, m_c1);
        chk("m_in_service", in_service, m_is);
    endtask

    task automatic do_reset();
        ie = 8'h00; ip = 8'h00; it0 = 0; it1 = 0; int0_n = 1; int1_n = 1;
        tf0 = 0; tf1 = 0; ri_ti = 0;
        reset = 0;
        tick();
        reset = 1;
    endtask

    task automatic wait_req(int max);
        int n = 0;
        while (int_req !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk("wait_req", int_req, 1);
    endtask

    task automatic setup_nested();
        do_reset();
        ip = 8'h04; ie = 8'h86; it1 = 1; tf0 = 1;
        tick();
        chk("nest_tf0_src", int_src, 3'd1);
        int_ack = 1;
        tick();
        chk("nest_is_low", in_service, 2'b01);
        int1_n = 0;
        wait_req(8);
        chk("nest_ie1_src", int_src, 3'd2);
        chk("nest_ie1_vec", int_vector, 16'h0013);
    endtask

    initial begin
        do_reset();
        chk("rst_req", int_req, 0);
        chk("rst_vec", int_vector, 16'h0000);
        chk("rst_is", in_service, 2'b00);

        // basic timer vector
        ie = 8'h82; tf0 = 1;
        tick();
        chk("t1_req", int_req, 1);
        chk("t1_vec", int_vector, 16'h000B);
        chk("t1_src", int_src, 3'd1);
        int_ack = 1;
        tick();
        chk("t1_clr_tf0", clr_tf0, 1);
        chk("t1_is", in_service, 2'b01);
        chk("t1_req_drop", int_req, 0);

        // edge mode INT0
        do_reset();
        ie = 8'h81; it0 = 1; int0_n = 0;
        tick(); tick();
        chk("t2_flag_early", ie0_flag, 0);
        tick();
        chk("t2_flag_set", ie0_flag, 1);
        tick();
        chk("t2_req", int_req, 1);
        chk("t2_vec", int_vector, 16'h0003);
        int_ack = 1;
        tick();
        chk("t2_flag_clr", ie0_flag, 0);
        repeat (6) begin
            tick();
            chk("t2_no_rereq", int_req, 0);
        end

        // level mode INT0
        do_reset();
        ie = 8'h81; it0 = 0; int0_n = 0;
        repeat (3) tick();
        chk("t3_flag", ie0_flag, 1);
        tick();
        chk("t3_req", int_req, 1);
        int_ack = 1;
        tick();
        chk("t3_flag_kept", ie0_flag, 1);
        repeat (4) begin
            tick();
            chk("t3_blocked", int_req, 0);
        end
        reti = 1;
        tick();
        chk("t3_is_clear", in_service, 2'b00);
        tick();
        chk("t3_rereq", int_req, 1);

        // in-level priority
        do_reset();
        int0_n = 0;
        repeat (4) tick();
        ie = 8'h89; tf1 = 1;
        tick();
        chk("t4_ie0_wins", int_src, 3'd0);
        do_reset();
        int0_n = 0;
        repeat (4) tick();
        ip = 8'h08; ie = 8'h89; tf1 = 1;
        tick();
        chk("t4_tf1_wins", int_src, 3'd3);
        chk("t4_tf1_vec", int_vector, 16'h001B);

        // nesting
        setup_nested();
        int_ack = 1;
        tick();
        chk("t5_is_both", in_service, 2'b11);
        repeat (4) begin
            tick();
            chk("t5_low_blocked", int_req, 0);
        end
        reti = 1;
        tick();
        chk("t5_reti1", in_service, 2'b01);
        tick();
        chk("t5_still_blocked", int_req, 0);
        reti = 1;
        tick();
        chk("t5_reti2", in_service, 2'b00);
        tick();
        chk("t5_low_granted", int_req, 1);
        chk("t5_low_src", int_src, 3'd1);

        // EA cleared while request is locked
        do_reset();
        ie = 8'h82; tf0 = 1;
        tick();
        ie = 8'h00;
        repeat (3) begin
            tick();
            chk("t6_held_req", int_req, 1);
            chk("t6_held_vec", int_vector, 16'h000B);
        end
        int_ack = 1;
        tick();
        chk("t6_ack_drop", int_req, 0);

        // reset in REQ
        setup_nested();
        reset = 0;
        tick();
        reset = 1;
        chk("t6_rst_req", int_req, 0);
        chk("t6_rst_is", in_service, 2'b00);

        // reti and ack together
        setup_nested();
        reti = 1; int_ack = 1;
        tick();
        chk("t6_reti_ack", in_service, 2'b10);

        // randomized phase
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) ie = {($urandom_range(0, 3) != 0), 2'b00, 5'($urandom)};
            if ($urandom_range(0, 15) == 0) ip = {3'b000, 5'($urandom)};
            if ($urandom_range(0, 31) == 0) it0 = ~it0;
            if ($urandom_range(0, 31) == 0) it1 = ~it1;
            if ($urandom_range(0, 5) == 0) int0_n = ~int0_n;
            if ($urandom_range(0, 5) == 0) int1_n = ~int1_n;
            if ($urandom_range(0, 9) == 0) tf0 = ~tf0;
            if ($urandom_range(0, 9) == 0) tf1 = ~tf1;
            if ($urandom_range(0, 11) == 0) ri_ti = ~ri_ti;
            int_ack  = ($urandom_range(0, 2) == 0);
            reti     = ($urandom_range(0, 7) == 0);
            flag_clr = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
            reset    = ($urandom_range(0, 199) != 0);
            tick();
            reset = 1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
